// File: rtl/frame_write_controller_if.sv
// Frame-writer bus bundle: upstream 16-bit word stream (valid/ready) plus the
// frame-buffer write port. "master" is the controller's view, "slave" the surroundings.
interface frame_write_controller_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                  word_valid;
  logic [15:0]           word_data;
  logic                  word_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [2:0]            pixel;
  logic                  write_enable;

  modport master (
    input  word_valid,
    input  word_data,
    output word_ready,
    output address,
    output pixel,
    output write_enable
  );

  modport slave (
    output word_valid,
    output word_data,
    input  word_ready,
    input  address,
    input  pixel,
    input  write_enable
  );
endinterface

// File: rtl/frame_write_controller.sv
// Writes one 3-bit-per-pixel frame into the VGA frame buffer, optionally clearing it
// first, by slicing a continuous 16-bit word stream into pixels.
//
// state   | meaning
// S_IDLE  | waiting for start, no writes
// S_CLEAR | writing CLEAR_COLOUR to every address
// S_FILL  | pulling words, emitting one pixel write per enabled cycle when >=3 bits buffered
// S_DONE  | frame complete, imageDisplayed held high until the next start
module frame_write_controller #(
  parameter int unsigned PIXEL_COUNT  = 19200,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic clock,
  input  logic resetN,
  input  logic start_i,
  input  logic clear_first_i,
  input  logic user_enable_i,
  output logic busy_o,
  output logic frame_done_o,
  output logic image_displayed_o,
  frame_write_controller_if.master fb_if
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [17:0]           buf_q, buf_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [2:0]            pixel_q, pixel_d;
  logic                  write_en_q, write_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  displayed_q, displayed_d;
  logic                  word_ready;
  logic                  word_hs;

  assign word_ready = (state_q == S_FILL) && user_enable_i && (bit_cnt_q < 5'd3);
  assign word_hs    = word_ready && fb_if.word_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    bit_cnt_d    = bit_cnt_q;
    address_d    = address_q;
    pixel_d      = pixel_q;
    write_en_d   = 1'b0;
    frame_done_d = 1'b0;
    displayed_d  = displayed_q;
    if (user_enable_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d     = clear_first_i ? S_CLEAR : S_FILL;
            cnt_d       = '0;
            displayed_d = 1'b0;
          end
        end
        S_CLEAR: begin
          address_d  = cnt_q;
          pixel_d    = CLEAR_COLOUR;
          write_en_d = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
        S_FILL: begin
          // Buffer is MSB-aligned; a new word lands directly below the 0..2 leftover bits.
          if (word_hs) begin
            buf_d     = buf_q | ({fb_if.word_data, 2'b00} >> bit_cnt_q);
            bit_cnt_d = bit_cnt_q + 5'd16;
          end else if (bit_cnt_q >= 5'd3) begin
            pixel_d    = buf_q[17:15];
            address_d  = cnt_q;
            write_en_d = 1'b1;
            buf_d      = {buf_q[14:0], 3'b000};
            bit_cnt_d  = bit_cnt_q - 5'd3;
            if (cnt_q == LAST_ADDR) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
              displayed_d  = 1'b1;
              cnt_d        = '0;
              buf_d        = '0;
              bit_cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      buf_q        <= '0;
      bit_cnt_q    <= '0;
      address_q    <= '0;
      pixel_q      <= '0;
      write_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      displayed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      bit_cnt_q    <= bit_cnt_d;
      address_q    <= address_d;
      pixel_q      <= pixel_d;
      write_en_q   <= write_en_d;
      frame_done_q <= frame_done_d;
      displayed_q  <= displayed_d;
    end
  end

  assign fb_if.word_ready   = word_ready;
  assign fb_if.address      = address_q;
  assign fb_if.pixel        = pixel_q;
  assign fb_if.write_enable = write_en_q;
  assign busy_o             = (state_q == S_CLEAR) || (state_q == S_FILL);
  assign frame_done_o       = frame_done_q;
  assign image_displayed_o  = displayed_q;

endmodule

// File: tb/tb_frame_write_controller.sv
// Bench for frame_write_controller: driver issues frames and words, a negedge monitor
// compares every write and status output against a bitstream reference model.
module tb_frame_write_controller;
  localparam int PC = 19200;
  localparam int AW = 15;

  logic clock;
  logic resetN;
  logic start;
  logic clear_first;
  logic user_enable;
  logic busy;
  logic frame_done;
  logic displayed;

  frame_write_controller_if #(.ADDR_WIDTH(AW)) wif ();

  frame_write_controller #(
    .PIXEL_COUNT (PC),
    .ADDR_WIDTH  (AW),
    .CLEAR_COLOUR(3'b000)
  ) dut (
    .clock            (clock),
    .resetN           (resetN),
    .start_i          (start),
    .clear_first_i    (clear_first),
    .user_enable_i    (user_enable),
    .busy_o           (busy),
    .frame_done_o     (frame_done),
    .image_displayed_o(displayed),
    .fb_if            (wif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {M_IDLE, M_CLEAR, M_FILL, M_DONE} mphase_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  pix;
    logic        done;
    logic        clr_last;
  } exp_t;

  // monitor-owned model state
  exp_t    expq[$];
  bit      bitq[$];
  mphase_t m_phase    = M_IDLE;
  bit      m_disp     = 1'b0;
  int      pend       = 0;
  int      fill_next  = 0;
  int      last_addr  = 0;
  int      done_count = 0;
  bit      exp_we     = 1'b0;
  bit      rst_prev   = 1'b0;
  bit      hs_q       = 1'b0;
  int      start_seen = 0;
  bit      mon_done   = 1'b0;
  int      chk_cnt    = 0;
  int      pass_cnt   = 0;

  // driver-owned
  int          start_evt_cnt = 0;
  bit          start_evt_clr = 1'b0;
  int          timeout_evt   = 0;
  bit          end_req       = 1'b0;
  bit          ffff_mode     = 1'b0;
  logic [15:0] preq[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    bit          hs;
    logic [2:0]  p;
    if (!rst_prev) begin
      chk("rst_address", 32'(wif.address), 32'd0);
      chk("rst_pixel", 32'(wif.pixel), 32'd0);
      chk("rst_write_enable", 32'(wif.write_enable), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      expq.delete();
      bitq.delete();
      pend      = 0;
      fill_next = 0;
      last_addr = 0;
      m_phase   = M_IDLE;
      m_disp    = 1'b0;
    end else begin
      chk("write_enable", 32'(wif.write_enable), 32'(exp_we));
      if (wif.write_enable) begin
        chk("write_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("address", 32'(wif.address), e.addr);
          chk("pixel", 32'(wif.pixel), 32'(e.pix));
          chk("frame_done", 32'(frame_done), 32'(e.done));
          last_addr = int'(e.addr);
          if (m_phase == M_FILL) pend -= 3;
          if (e.clr_last) m_phase = M_FILL;
          if (e.done) begin
            m_phase = M_DONE;
            m_disp  = 1'b1;
            pend    = 0;
            done_count++;
          end
        end
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'd0);
        chk("address_hold", 32'(wif.address), 32'(last_addr));
      end
    end

    if (start_seen != start_evt_cnt) begin
      start_seen = start_evt_cnt;
      m_phase    = start_evt_clr ? M_CLEAR : M_FILL;
      m_disp     = 1'b0;
      fill_next  = 0;
      if (start_evt_clr) begin
        for (int a = 0; a < PC; a++) begin
          e.addr     = 32'(a);
          e.pix      = 3'b000;
          e.done     = 1'b0;
          e.clr_last = (a == PC - 1);
          expq.push_back(e);
        end
      end
    end

    chk("busy", 32'(busy), 32'(m_phase == M_CLEAR || m_phase == M_FILL));
    chk("image_displayed", 32'(displayed), 32'(m_disp));
    chk("word_ready", 32'(wif.word_ready), 32'(m_phase == M_FILL && user_enable && pend < 3));

    hs = resetN && wif.word_valid && wif.word_ready;
    if (hs) begin
      pend += 16;
      for (int i = 15; i >= 0; i--) bitq.push_back(wif.word_data[i]);
      while (bitq.size() >= 3 && fill_next < PC) begin
        p[2] = bitq.pop_front();
        p[1] = bitq.pop_front();
        p[0] = bitq.pop_front();
        e.addr     = 32'(fill_next);
        e.pix      = p;
        e.done     = (fill_next == PC - 1);
        e.clr_last = 1'b0;
        expq.push_back(e);
        if (fill_next == PC - 1) bitq.delete();
        fill_next++;
      end
    end
    hs_q = hs;
    exp_we = resetN && user_enable &&
             (m_phase == M_CLEAR || (m_phase == M_FILL && pend >= 3 && !hs));
    rst_prev = resetN;

    if (end_req && !mon_done) begin
      chk("wait_bounds", 32'(timeout_evt), 32'd0);
      chk("frame_done_count", 32'(done_count), 32'd1);
      mon_done = 1'b1;
    end
  end

  function automatic logic [15:0] next_word();
    if (preq.size() != 0) return preq.pop_front();
    if (ffff_mode) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  task automatic tick(input int valid_pct);
    @(posedge clock);
    #1;
    if (hs_q) wif.word_data = next_word();
    wif.word_valid = (int'($urandom_range(0, 99)) < valid_pct);
  endtask

  task automatic do_start(input bit clr, input int pct);
    user_enable = 1'b1;
    start       = 1'b1;
    clear_first = clr;
    tick(pct);
    start         = 1'b0;
    clear_first   = 1'($urandom_range(0, 1));
    start_evt_clr = clr;
    start_evt_cnt++;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(75);
    tick(75);
    resetN = 1'b1;
  endtask

  initial begin
    int n;
    resetN         = 1'b0;
    start          = 1'b0;
    clear_first    = 1'b0;
    user_enable    = 1'b1;
    wif.word_valid = 1'b0;
    wif.word_data  = 16'($urandom);
    repeat (3) tick(0);
    resetN = 1'b1;
    tick(0);

    // Frame A: random words, stall at bitCount=1, pause, reset mid-frame
    do_start(1'b0, 100);
    n = 0;
    while (!(m_phase == M_FILL && pend == 4 && !hs_q) && n < 200) begin tick(100); n++; end
    if (n >= 200) timeout_evt++;
    wif.word_valid = 1'b0;
    repeat (10) tick(0);
    repeat (30) tick(75);
    user_enable = 1'b0;
    repeat (5) tick(75);
    user_enable = 1'b1;
    n = 0;
    while (!(m_phase == M_FILL && last_addr >= 500) && n < 3000) begin tick(75); n++; end
    if (n >= 3000) timeout_evt++;
    do_reset();
    tick(50);

    // Frame A2: word boundary packing from an empty buffer
    wif.word_data = 16'hB6DB;
    preq.push_back(16'h6DB6);
    do_start(1'b0, 100);
    repeat (40) tick(100);
    do_reset();
    tick(50);

    // Frame B: clear then fill with all-ones, pauses and ignored starts
    ffff_mode     = 1'b1;
    wif.word_data = 16'hFFFF;
    do_start(1'b1, 100);
    n = 0;
    while (!(m_phase == M_CLEAR && last_addr >= 100) && n < 1000) begin tick(100); n++; end
    if (n >= 1000) timeout_evt++;
    user_enable = 1'b0;
    repeat (5) tick(100);
    user_enable = 1'b1;
    start = 1'b1;
    clear_first = 1'b0;
    tick(100);
    start = 1'b0;
    n = 0;
    while (m_phase != M_FILL && n < 25000) begin tick(100); n++; end
    if (n >= 25000) timeout_evt++;
    repeat (50) tick(100);
    start = 1'b1;
    clear_first = 1'b1;
    tick(100);
    start = 1'b0;
    user_enable = 1'b0;
    repeat (5) tick(100);
    user_enable = 1'b1;
    n = 0;
    while (m_phase != M_DONE && n < 30000) begin tick(100); n++; end
    if (n >= 30000) timeout_evt++;
    repeat (10) tick(100);

    // Frame C: restart from DONE, then abort
    ffff_mode = 1'b0;
    do_start(1'b0, 100);
    repeat (30) tick(90);
    do_reset();
    repeat (3) tick(0);

    end_req = 1'b1;
    n = 0;
    while (!mon_done && n < 10) begin tick(0); n++; end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/frame_write_controller.md
Name: frame_write_controller

Overview:
- Sequences one complete encrypted-image frame into the 160x120, 3-bit-per-pixel VGA frame buffer.
- Optionally clears the buffer first. It then pulls 16-bit encrypted words from the upstream submatrix stage over a valid/ready handshake and treats them as one continuous bitstream.
- It cuts that stream into 3-bit pixels and issues exactly one frame-buffer write per pixel at sequential addresses.
- It owns the frame buffer write port for the whole frame and reports completion.

Parameters:
- PIXEL_COUNT, 19200, pixels per frame; the last address is PIXEL_COUNT-1.
- ADDR_WIDTH, 15, width of the address output.
- CLEAR_COLOUR, 3'b000, pixel value written during the clear phase.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  synchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE or DONE.
- clearFirst  in  1  sampled together with start; 1 = run the CLEAR phase before FILL.
- userEnable  in  1  0 = pause: all state frozen, no writes, wordReady=0.
- wordValid  in  1  upstream word available.
- wordData  in  16  encrypted word; bit 15 is consumed first.
- wordReady  out  1  controller accepts wordData this cycle (combinational).
- address  out  ADDR_WIDTH  frame-buffer write address (registered).
- pixel  out  3  frame-buffer write data (registered).
- writeEnable  out  1  frame-buffer write strobe (registered).
- busy  out  1  high in CLEAR or FILL.
- frameDone  out  1  one-cycle pulse when the last pixel write is issued.
- imageDisplayed  out  1  level, high in DONE until the next accepted start.

Behaviour:
- Reset (resetN=0 at an edge, in any state, including mid-frame):
  - state goes to IDLE; bit buffer is emptied (bitCount=0); pixel counter = 0.
  - address=0, pixel=0, writeEnable=0, frameDone=0, imageDisplayed=0, busy=0, wordReady=0.
- State machine: IDLE, CLEAR, FILL, DONE.
- IDLE/DONE:
  - start=1 with userEnable=1 moves to CLEAR if clearFirst=1, else to FILL.
  - On that transition the pixel counter is set to 0 and imageDisplayed drops.
- Pause: every state-changing rule below applies only in cycles where userEnable=1. With userEnable=0:
  - nothing changes.
  - writeEnable is 0 on the following cycle.
  - wordReady=0.
- CLEAR:
  - Each enabled cycle registers address=counter, pixel=CLEAR_COLOUR, writeEnable=1, then increments the counter.
  - After address PIXEL_COUNT-1 is issued, the counter resets to 0 and the state moves to FILL.
  - The bit buffer is untouched. No words are accepted.
- FILL, bit buffer:
  - The buffer is 18 bits wide with a bitCount of 0..18.
  - wordReady = (state==FILL) && userEnable && bitCount<3.
  - A handshake (wordValid && wordReady) appends wordData below the remaining bits; bitCount += 16.
  - No pixel is emitted in a handshake cycle.
- FILL, pixel emission:
  - Each enabled cycle with bitCount>=3 emits the top 3 buffered bits: pixel = those bits, address = counter, writeEnable = 1.
  - bitCount -= 3; the counter increments.
  - The steady pattern is 3 words -> 16 pixels in 19 cycles; bitCount cycles 16->1, 17->2, 18->0.
- FILL, stall: bitCount<3 with wordValid=0 means no write and an idle cycle.
- FILL, termination:
  - The write with address=PIXEL_COUNT-1 moves the state to DONE.
  - frameDone pulses in that same registered cycle as the last writeEnable.
  - Residual buffered bits are discarded; with the default there are none, since 3600 words = 57600 bits.
- DONE: no writes; wordReady=0; busy=0; imageDisplayed=1.
- start while busy is ignored; clearFirst is ignored outside the start cycle.
- writeEnable is never high for more than one cycle per address within a phase; address never exceeds PIXEL_COUNT-1.
- Counter width is ADDR_WIDTH. PIXEL_COUNT-1 must fit in it; it is compared exactly, with no wrap-around.

Test Plan:
- Reset check: hold resetN=0 for 2 cycles mid-FILL (address=500). All outputs read 0, state IDLE. A following start with clearFirst=0 begins at address 0 with an empty buffer.
- Clear then fill: start with clearFirst=1, wordValid held 1.
  - 19200 consecutive writes of pixel=0, addresses 0..19199.
  - Next, wordData=16'hFFFF repeated gives pixels 3'b111 from address 0.
  - frameDone pulses once with the write at 19199; imageDisplayed=1 afterwards.
- Bit packing across words: without clear, feed 16'hB6DB then 16'h6DB6.
  - Pixels 0..4 are 101,101,101,101,101.
  - Pixel 5 is formed from the last bit of word 1 plus the first two of word 2.
  - Words are accepted only when bitCount<3.
- Backpressure/stall: wordValid low for 10 cycles while bitCount=1. No writeEnable during the gap, wordReady stays 1, address is unchanged, and the write resumes right after the handshake.
- Pause: drop userEnable for 5 cycles mid-CLEAR and mid-FILL. No writes and wordReady=0 during the pause; on resume the sequence continues with no skipped or repeated address.
- Start handling: pulse start while busy and get no effect. start in DONE restarts the frame and clears imageDisplayed the following cycle.
